// File: rtl/insts_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: FSM state encoding,
// default geometry and the LFSR seed/taps used by the optional random stall.
package insts_fetch_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

  localparam int DEF_NUM_INSTS = 4;
  localparam int DEF_INST_BITS = 32;
  localparam int DEF_ADDR_BITS = 64;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/insts_fetch_responder_mem.sv
// Instruction store: single write port plus a NUM_INSTS-lane combinational
// bundle read. Lanes that fall below BASE_ADDR, past the end of the store, or
// belong to a misaligned request read 0 and raise their out-of-range flag.
module insts_mem_array #(
  parameter int                   NUM_INSTS       = 4,
  parameter int                   INST_BITS       = 32,
  parameter int                   ADDR_BITS       = 64,
  parameter int                   MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR       = '0
) (
  input  logic                                     clk,
  input  logic                                     load_valid,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0]       load_word_addr,
  input  logic [INST_BITS-1:0]                     load_data,
  input  logic [ADDR_BITS-1:0]                     rd_addr,
  output logic [NUM_INSTS-1:0][INST_BITS-1:0]      rd_bundle,
  output logic [NUM_INSTS-1:0]                     rd_oor
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  logic [INST_BITS-1:0] mem [MEM_DEPTH_WORDS];
  logic [ADDR_BITS-1:0] offset, idx;
  logic                 bad;

  // Store write; never reset so contents survive reset_in
  always_ff @(posedge clk) begin
    if (load_valid) mem[load_word_addr] <= load_data;
  end

  // Underflow comes from the compare, not the sign of the difference
  always_comb begin
    offset = rd_addr - BASE_ADDR;
    idx    = offset >> 2;
    bad    = (rd_addr < BASE_ADDR) || (rd_addr[1:0] != 2'b00);
  end

  for (genvar i = 0; i < NUM_INSTS; i++) begin : g_lane
    logic [ADDR_BITS-1:0] word;
    logic                 in_range;
    assign word         = idx + ADDR_BITS'(i);
    assign in_range     = !bad && (word < ADDR_BITS'(MEM_DEPTH_WORDS));
    assign rd_bundle[i] = in_range ? mem[word[AW-1:0]] : '0;
    assign rd_oor[i]    = !in_range;
  end

endmodule

// File: rtl/insts_fetch_responder.sv
// Memory-side responder for the instruction fetcher: IDLE -> ACK -> WAIT -> RESP.
// Optional macro INSTS_FETCH_RESP_RANDOM_STALL_EN adds 0..3 LFSR-driven extra
// wait cycles per request; without it the latency is fixed at LATENCY.
module insts_fetch_responder
  import insts_fetch_responder_pkg::*;
#(
  parameter int                   NUM_INSTS       = DEF_NUM_INSTS,
  parameter int                   INST_BITS       = DEF_INST_BITS,
  parameter int                   ADDR_BITS       = DEF_ADDR_BITS,
  parameter int                   MEM_DEPTH_WORDS = 1024,
  parameter int                   LATENCY         = 2,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR       = '0
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [ADDR_BITS-1:0]                insts_fetch_addr_in,
  input  logic                                insts_fetch_addr_valid_in,
  output logic                                insts_fetch_ack_out,
  output logic                                insts_fetch_valid_out,
  output logic [NUM_INSTS*INST_BITS-1:0]      insts_fetch_out,
  output logic                                insts_fetch_fault_out,
  input  logic                                load_valid_in,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0]  load_word_addr_in,
  input  logic [INST_BITS-1:0]                load_data_in
);

  localparam int CW = 5;  // holds LATENCY (<=15) plus up to 3 extra

  fetch_state_e                         state;
  logic [NUM_INSTS-1:0][INST_BITS-1:0]  rd_bundle, cap_bundle;
  logic [NUM_INSTS-1:0]                 rd_oor;
  logic                                 cap_fault;
  logic [1:0]                           cap_extra, extra_now;
  logic [CW-1:0]                        cnt, wait_total;

  insts_mem_array #(
    .NUM_INSTS      (NUM_INSTS),
    .INST_BITS      (INST_BITS),
    .ADDR_BITS      (ADDR_BITS),
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS),
    .BASE_ADDR      (BASE_ADDR)
  ) u_mem (
    .clk           (clk_in),
    .load_valid    (load_valid_in),
    .load_word_addr(load_word_addr_in),
    .load_data     (load_data_in),
    .rd_addr       (insts_fetch_addr_in),
    .rd_bundle     (rd_bundle),
    .rd_oor        (rd_oor)
  );

`ifdef INSTS_FETCH_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Advance once per accepted request
  always_ff @(posedge clk_in) begin
    if (reset_in)                                           lfsr <= LFSR_SEED;
    else if (state == ST_IDLE && insts_fetch_addr_valid_in) lfsr <= lfsr_next(lfsr);
  end

  assign extra_now = lfsr[1:0];
`else
  assign extra_now = 2'd0;
`endif

  assign wait_total = CW'(LATENCY) + CW'(cap_extra);

  // Request FSM; every output is registered and set on entry to its state
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state                 <= ST_IDLE;
      insts_fetch_ack_out   <= 1'b0;
      insts_fetch_valid_out <= 1'b0;
      insts_fetch_out       <= '0;
      insts_fetch_fault_out <= 1'b0;
      cap_bundle            <= '0;
      cap_fault             <= 1'b0;
      cap_extra             <= 2'd0;
      cnt                   <= '0;
    end else begin
      insts_fetch_ack_out   <= 1'b0;
      insts_fetch_valid_out <= 1'b0;
      case (state)
        ST_IDLE: if (insts_fetch_addr_valid_in) begin
          cap_bundle          <= rd_bundle;
          cap_fault           <= |rd_oor;
          cap_extra           <= extra_now;
          insts_fetch_ack_out <= 1'b1;
          state               <= ST_ACK;
        end
        ST_ACK: begin
          cnt <= wait_total;
          if (wait_total != '0) begin
            state <= ST_WAIT;
          end else begin
            state                 <= ST_RESP;
            insts_fetch_valid_out <= 1'b1;
            insts_fetch_out       <= cap_bundle;
            insts_fetch_fault_out <= cap_fault;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            state                 <= ST_RESP;
            insts_fetch_valid_out <= 1'b1;
            insts_fetch_out       <= cap_bundle;
            insts_fetch_fault_out <= cap_fault;
          end
        end
        default: state <= ST_IDLE;  // RESP lasts one cycle
      endcase
    end
  end

endmodule
